ps2_keycode: RTL and testbench

- Receives scan codes from a PS/2 keyboard on the two-wire PS2_CLK/PS2_DAT interface.
- Decodes make and break sequences into the held-key `keycode` bus that the game logic, user ship and laser consume: the producer side of that bus.
- Sits between the board PS/2 pins and the game controller.
- Single-key model: `keycode` holds the most recently pressed key and returns to 0 when that key is released.

---
 rtl/ps2_keycode.sv | 244 ++++++++++++++++++++++++
 tb/tb_ps2_keycode.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_keycode.sv
// ps2_keycode
//   PS/2 keyboard receiver and single-key decoder. Conditions the raw
//   PS2_CLK/PS2_DAT pins, deframes 11-bit frames (start, 8 data LSB-first,
//   odd parity, stop) and turns make/break sequences into a held-key code.
//
// Ports
//   Clk        in   system clock (50 MHz)
//   Reset      in   asynchronous active-low reset
//   PS2_CLK    in   raw keyboard clock, asynchronous to Clk
//   PS2_DAT    in   raw keyboard data, asynchronous to Clk
//   keycode    out  [7:0] currently held key, 8'h00 = none
//   key_valid  out  one-cycle pulse whenever keycode changes
//   frame_err  out  one-cycle pulse on parity, stop-bit or timeout error
//
// Parameters
//   FILTER_LEN   consecutive samples needed to move the filtered clock level
//   TIMEOUT_CYC  Clk cycles without a falling edge before a frame is dropped
//
// Build option
//   PS2_EXT_EN   when defined, bytes following an E0 prefix decode like
//                normal keys; otherwise they are dropped.
//
// state    | meaning
// ---------+---------------------------------------------------
// S_IDLE   | waiting for a start bit (data low on a falling edge)
// S_DATA   | shifting in the 8 data bits, LSB first
// S_PARITY | capturing the parity bit
// S_STOP   | checking stop bit and odd parity, accepting the byte

module ps2_keycode #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 10000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [7:0] keycode,
  output logic       key_valid,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  // input conditioning
  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          filt_lvl;
  logic [FW-1:0] filt_cnt;
  logic          fall;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= PS2_CLK;
      clk_s2 <= clk_s1;
      dat_s1 <= PS2_DAT;
      dat_s2 <= dat_s1;
    end
  end

  // The level only moves after FILTER_LEN agreeing samples; any sample
  // matching the current level restarts the count, rejecting glitches.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      filt_lvl <= 1'b1;
      filt_cnt <= '0;
      fall     <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (clk_s2 != filt_lvl) begin
        if (filt_cnt == FW'(FILTER_LEN - 1)) begin
          filt_lvl <= clk_s2;
          filt_cnt <= '0;
          fall     <= ~clk_s2;
        end else begin
          filt_cnt <= filt_cnt + 1'b1;
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  // frame FSM
  state_t        state, state_nxt;
  logic [2:0]    bitcnt, bitcnt_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic          par_bit, par_nxt;
  logic [TW-1:0] to_cnt, to_nxt;
  logic          timeout;
  logic          acc, err;

  assign timeout = (state != S_IDLE) && (to_cnt == TW'(TIMEOUT_CYC - 1));

  always_comb begin
    state_nxt  = state;
    bitcnt_nxt = bitcnt;
    shreg_nxt  = shreg;
    par_nxt    = par_bit;
    to_nxt     = (state != S_IDLE) ? to_cnt + 1'b1 : '0;
    acc        = 1'b0;
    err        = 1'b0;
    // the timeout takes priority over a coincident falling edge
    if (timeout) begin
      err       = 1'b1;
      state_nxt = S_IDLE;
      to_nxt    = '0;
    end else if (fall) begin
      to_nxt = '0;
      case (state)
        S_IDLE: begin
          if (!dat_s2) begin
            state_nxt  = S_DATA;
            bitcnt_nxt = 3'd0;
          end
        end
        S_DATA: begin
          shreg_nxt = {dat_s2, shreg[7:1]};
          if (bitcnt == 3'd7) begin
            state_nxt = S_PARITY;
          end else begin
            bitcnt_nxt = bitcnt + 3'd1;
          end
        end
        S_PARITY: begin
          par_nxt   = dat_s2;
          state_nxt = S_STOP;
        end
        S_STOP: begin
          state_nxt = S_IDLE;
          if (dat_s2 && ((^shreg) ^ par_bit)) begin
            acc = 1'b1;
          end else begin
            err = 1'b1;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  logic       byte_acc;
  logic [7:0] byte_q;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= S_IDLE;
      bitcnt    <= 3'd0;
      shreg     <= 8'h00;
      par_bit   <= 1'b0;
      to_cnt    <= '0;
      byte_acc  <= 1'b0;
      byte_q    <= 8'h00;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      bitcnt    <= bitcnt_nxt;
      shreg     <= shreg_nxt;
      par_bit   <= par_nxt;
      to_cnt    <= to_nxt;
      byte_acc  <= acc;
      frame_err <= err;
      if (acc) begin
        byte_q <= shreg;
      end
    end
  end

  // byte decode
  logic       break_pend, bp_nxt;
  logic       ext_pend, ep_nxt;
  logic [7:0] kc_nxt;
  logic       kv_nxt;
  logic       ext_drop;

`ifdef PS2_EXT_EN
  // the E0 prefix is still tracked but never blocks the following byte
  assign ext_drop = ext_pend & 1'b0;
`else
  assign ext_drop = ext_pend;
`endif

  always_comb begin
    kc_nxt = keycode;
    kv_nxt = 1'b0;
    bp_nxt = break_pend;
    ep_nxt = ext_pend;
    if (err) begin
      bp_nxt = 1'b0;
      ep_nxt = 1'b0;
    end else if (byte_acc) begin
      if (byte_q == 8'hF0) begin
        bp_nxt = 1'b1;
      end else if (byte_q == 8'hE0) begin
        ep_nxt = 1'b1;
      end else if (ext_drop) begin
        bp_nxt = 1'b0;
        ep_nxt = 1'b0;
      end else if (break_pend) begin
        // a break for a key other than the held one is ignored
        if ((byte_q == keycode) && (keycode != 8'h00)) begin
          kc_nxt = 8'h00;
          kv_nxt = 1'b1;
        end
        bp_nxt = 1'b0;
        ep_nxt = 1'b0;
      end else begin
        // typematic repeats of the held key do not pulse
        if (byte_q != keycode) begin
          kc_nxt = byte_q;
          kv_nxt = 1'b1;
        end
        ep_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      keycode    <= 8'h00;
      key_valid  <= 1'b0;
      break_pend <= 1'b0;
      ext_pend   <= 1'b0;
    end else begin
      keycode    <= kc_nxt;
      key_valid  <= kv_nxt;
      break_pend <= bp_nxt;
      ext_pend   <= ep_nxt;
    end
  end

endmodule

// File: tb/tb_ps2_keycode.sv
module tb_ps2_keycode;

  localparam int TIMEOUT_CYC = 10000;
  localparam int HP          = 40;
`ifdef PS2_EXT_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       PS2_CLK = 1'b1;
  logic       PS2_DAT = 1'b1;
  logic [7:0] keycode;
  logic       key_valid;
  logic       frame_err;

  ps2_keycode #(.FILTER_LEN(8), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .Clk(Clk), .Reset(Reset), .PS2_CLK(PS2_CLK), .PS2_DAT(PS2_DAT),
    .keycode(keycode), .key_valid(key_valid), .frame_err(frame_err)
  );

  always #10 Clk = ~Clk;

  int n_assert = 0;
  int n_fail   = 0;

  // observed pulse counts and invariants
  int         kv_cnt = 0, fe_cnt = 0, cyc = 0, fe_cyc = 0;
  bit         overlap = 0, silent_change = 0;
  logic [7:0] prev_kc = 8'h00;

  always @(negedge Clk) begin
    if (key_valid === 1'b1) kv_cnt++;
    if (frame_err === 1'b1) begin
      fe_cnt++;
      fe_cyc = cyc;
    end
    if (key_valid === 1'b1 && frame_err === 1'b1) overlap = 1;
    if (Reset && keycode !== prev_kc && key_valid !== 1'b1) silent_change = 1;
    prev_kc = keycode;
    cyc++;
  end

  // reference model: single held key, prefix flags
  logic [7:0] exp_key = 8'h00;
  int         exp_kv = 0, exp_fe = 0;
  bit         m_brk = 0, m_ext = 0;

  task automatic model_frame(input logic [7:0] b, input bit good);
    if (!good) begin
      exp_fe++;
      m_brk = 0;
      m_ext = 0;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (m_ext && !EXT) begin
      m_brk = 0;
      m_ext = 0;
    end else begin
      if (m_brk) begin
        if (b == exp_key && exp_key != 8'h00) begin
          exp_key = 8'h00;
          exp_kv++;
        end
      end else if (b != exp_key) begin
        exp_key = b;
        exp_kv++;
      end
      m_brk = 0;
      m_ext = 0;
    end
  endtask

  task automatic ps2_bit(input logic b, input int hp);
    @(negedge Clk);
    PS2_DAT = b;
    repeat (hp) @(negedge Clk);
    PS2_CLK = 1'b0;
    repeat (hp) @(negedge Clk);
    PS2_CLK = 1'b1;
  endtask

  task automatic xfer(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int hp);
    logic par;
    par = ~(^b) ^ bad_par;
    ps2_bit(1'b0, hp);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], hp);
    ps2_bit(par, hp);
    ps2_bit(~bad_stop, hp);
    PS2_DAT = 1'b1;
    repeat (2 * hp) @(negedge Clk);
    model_frame(b, !(bad_par || bad_stop));
  endtask

  task automatic test_reset();
    int kv0, fe0;
    logic [7:0] partial;
    Reset = 1'b0;
    repeat (5) @(negedge Clk);
    n_assert++;
    if (keycode !== 8'h00) begin n_fail++; $display("FAIL reset_keycode: got %h want 00", keycode); end
    n_assert++;
    if (key_valid !== 1'b0) begin n_fail++; $display("FAIL reset_key_valid: got %b want 0", key_valid); end
    n_assert++;
    if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    Reset = 1'b1;
    repeat (20) @(negedge Clk);
    partial = 8'h5A;
    ps2_bit(1'b0, HP);
    for (int i = 0; i < 4; i++) ps2_bit(partial[i], HP);
    kv0 = kv_cnt;
    fe0 = fe_cnt;
    Reset = 1'b0;
    repeat (20) @(negedge Clk);
    PS2_DAT = 1'b1;
    Reset = 1'b1;
    m_brk = 0;
    m_ext = 0;
    exp_key = 8'h00;
    repeat (50) @(negedge Clk);
    n_assert++;
    if (kv_cnt !== kv0 || fe_cnt !== fe0) begin
      n_fail++; $display("FAIL reset_midframe_pulses: kv %0d fe %0d want kv %0d fe %0d", kv_cnt, fe_cnt, kv0, fe0);
    end
    exp_kv = kv_cnt;
    exp_fe = fe_cnt;
    xfer(8'h1D, 0, 0, HP);
    n_assert++;
    if (keycode !== 8'h1D) begin n_fail++; $display("FAIL reset_then_1D: got %h want 1d", keycode); end
    n_assert++;
    if (kv_cnt !== kv0 + 1) begin n_fail++; $display("FAIL reset_then_1D_pulses: got %0d want %0d", kv_cnt - kv0, 1); end
  endtask

  task automatic test_make_break();
    int kv0;
    kv0 = kv_cnt;
    xfer(8'hF0, 0, 0, 3 * HP);
    n_assert++;
    if (keycode !== 8'h1D || kv_cnt !== kv0) begin
      n_fail++; $display("FAIL break_prefix: key %h pulses %0d want 1d / 0", keycode, kv_cnt - kv0);
    end
    xfer(8'h1D, 0, 0, 3 * HP);
    n_assert++;
    if (keycode !== 8'h00) begin n_fail++; $display("FAIL break_release: got %h want 00", keycode); end
    n_assert++;
    if (kv_cnt !== kv0 + 1) begin n_fail++; $display("FAIL break_pulses: got %0d want 1", kv_cnt - kv0); end
  endtask

  task automatic test_typematic();
    int kv0;
    kv0 = kv_cnt;
    for (int i = 0; i < 3; i++) begin
      xfer(8'h1C, 0, 0, HP);
      n_assert++;
      if (keycode !== 8'h1C) begin n_fail++; $display("FAIL typematic_%0d: got %h want 1c", i, keycode); end
    end
    xfer(8'hF0, 0, 0, HP);
    xfer(8'h23, 0, 0, HP);
    n_assert++;
    if (keycode !== 8'h1C) begin n_fail++; $display("FAIL break_other_key: got %h want 1c", keycode); end
    n_assert++;
    if (kv_cnt !== kv0 + 1) begin n_fail++; $display("FAIL typematic_pulses: got %0d want 1", kv_cnt - kv0); end
  endtask

  task automatic test_errors();
    int kv0, fe0;
    xfer(8'hF0, 0, 0, HP);
    xfer(8'h1C, 0, 0, HP);
    kv0 = kv_cnt;
    fe0 = fe_cnt;
    xfer(8'h1C, 1, 0, HP);
    xfer(8'h1C, 0, 1, HP);
    n_assert++;
    if (fe_cnt !== fe0 + 2) begin n_fail++; $display("FAIL err_pulses: got %0d want 2", fe_cnt - fe0); end
    n_assert++;
    if (keycode !== 8'h00 || kv_cnt !== kv0) begin
      n_fail++; $display("FAIL err_keycode: key %h pulses %0d want 00 / 0", keycode, kv_cnt - kv0);
    end
    xfer(8'h1B, 0, 0, HP);
    n_assert++;
    if (keycode !== 8'h1B) begin n_fail++; $display("FAIL err_recover: got %h want 1b", keycode); end
  endtask

  task automatic test_timeout();
    int fe0, t_low, waited;
    logic [7:0] partial;
    partial = 8'h3C;
    fe0 = fe_cnt;
    ps2_bit(1'b0, HP);
    for (int i = 0; i < 4; i++) ps2_bit(partial[i], HP);
    @(negedge Clk);
    PS2_DAT = partial[4];
    repeat (HP) @(negedge Clk);
    PS2_CLK = 1'b0;
    t_low = cyc;
    repeat (HP) @(negedge Clk);
    PS2_CLK = 1'b1;
    waited = 0;
    while (fe_cnt == fe0 && waited < 12000) begin
      @(negedge Clk);
      waited++;
    end
    n_assert++;
    if (fe_cnt !== fe0 + 1) begin
      n_fail++; $display("FAIL timeout_pulse: got %0d pulses want 1", fe_cnt - fe0);
    end else begin
      n_assert++;
      if (fe_cyc - t_low < TIMEOUT_CYC || fe_cyc - t_low > TIMEOUT_CYC + 40) begin
        n_fail++; $display("FAIL timeout_delay: got %0d cycles want %0d..%0d", fe_cyc - t_low, TIMEOUT_CYC, TIMEOUT_CYC + 40);
      end
    end
    exp_fe++;
    m_brk = 0;
    m_ext = 0;
    PS2_DAT = 1'b1;
    repeat (2 * HP) @(negedge Clk);
    xfer(8'h23, 0, 0, HP);
    n_assert++;
    if (keycode !== 8'h23) begin n_fail++; $display("FAIL timeout_recover: got %h want 23", keycode); end
  endtask

  task automatic test_ext();
    int kv0;
    xfer(8'hF0, 0, 0, HP);
    xfer(8'h23, 0, 0, HP);
    kv0 = kv_cnt;
    xfer(8'hE0, 0, 0, HP);
    xfer(8'h75, 0, 0, HP);
    n_assert++;
    if (keycode !== (EXT ? 8'h75 : 8'h00)) begin
      n_fail++; $display("FAIL ext_keycode: got %h want %h", keycode, EXT ? 8'h75 : 8'h00);
    end
    n_assert++;
    if (kv_cnt !== kv0 + (EXT ? 1 : 0)) begin
      n_fail++; $display("FAIL ext_pulses: got %0d want %0d", kv_cnt - kv0, EXT ? 1 : 0);
    end
  endtask

  task automatic test_random();
    logic [7:0] pool [8];
    logic [7:0] b;
    bit bp, bs;
    pool = '{8'h1C, 8'h1D, 8'h23, 8'h75, 8'hF0, 8'hF0, 8'hE0, 8'h1B};
    for (int i = 0; i < 16; i++) begin
      b  = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(1, 8'h7F)) : pool[$urandom_range(0, 7)];
      bp = ($urandom_range(0, 7) == 0);
      bs = !bp && ($urandom_range(0, 9) == 0);
      xfer(b, bp, bs, HP);
      n_assert++;
      if (keycode !== exp_key) begin n_fail++; $display("FAIL rand_key_%0d: got %h want %h (byte %h)", i, keycode, exp_key, b); end
      n_assert++;
      if (kv_cnt !== exp_kv) begin n_fail++; $display("FAIL rand_kv_%0d: got %0d want %0d", i, kv_cnt, exp_kv); end
      n_assert++;
      if (fe_cnt !== exp_fe) begin n_fail++; $display("FAIL rand_fe_%0d: got %0d want %0d", i, fe_cnt, exp_fe); end
    end
  endtask

  task automatic test_model_totals();
    n_assert++;
    if (kv_cnt !== exp_kv || fe_cnt !== exp_fe) begin
      n_fail++; $display("FAIL totals: kv %0d fe %0d want kv %0d fe %0d", kv_cnt, fe_cnt, exp_kv, exp_fe);
    end
    n_assert++;
    if (overlap) begin n_fail++; $display("FAIL pulse_overlap: got 1 want 0"); end
    n_assert++;
    if (silent_change) begin n_fail++; $display("FAIL keycode_without_pulse: got 1 want 0"); end
  endtask

  initial begin
    test_reset();
    test_make_break();
    test_typematic();
    test_errors();
    test_timeout();
    test_ext();
    test_random();
    test_model_totals();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
